// File: rtl/rand_index_sampler.sv
// rand_index_sampler
//   Turns the free-running LFSR word into a uniformly distributed index in
//   [0, limit) for the WalkSAT pick logic. Masked rejection sampling is used:
//   the candidate is the low IDX_W bits of rnd ANDed with the smallest
//   all-ones mask that covers limit-1. A draw at or above limit is rejected
//   and retried. Before every draw the block waits GAP clocks, because the
//   LFSR shifts in only one new bit per clock. After MAX_TRIES rejected draws
//   it folds the last candidate down (cand - limit). That value is always in
//   range, so the block always finishes.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   rnd          LFSR word; only rnd[IDX_W-1:0] is used
//   req_valid    request strobe
//   req_ready    high in IDLE only; decoded from state alone
//   limit        exclusive upper bound, latched when a request is accepted
//   idx_valid    result valid (DONE state)
//   idx_ready    consumer takes the result
//   idx          sampled index
//   idx_fallback result came from the fold-down path
//   err          limit was 0
module rand_index_sampler #(
  parameter int WIDTH     = 32,
  parameter int IDX_W     = 8,
  parameter int GAP       = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rnd,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] limit,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx,
  output logic             idx_fallback,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, DONE} state_e;

  localparam logic [7:0]       GAP_M1 = 8'(GAP - 1);
  localparam logic [7:0]       MT     = 8'(MAX_TRIES);
  localparam logic [IDX_W-1:0] ONE    = {{(IDX_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [IDX_W-1:0] lim_q, lim_d, mask_q, mask_d, idx_q, idx_d;
  logic [7:0]       try_q, try_d, gap_q, gap_d;
  logic             fb_q, fb_d, err_q, err_d;

  logic [IDX_W-1:0] lim_m1, mask_c, cand;

  // The upper LFSR bits are deliberately unused.
  if (WIDTH > IDX_W) begin : g_unused
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^rnd[WIDTH-1:IDX_W];
  end

  // Smear the highest set bit of limit-1 downward. This gives the smallest
  // 2^k-1 that is >= limit-1.
  always_comb begin
    lim_m1 = limit - ONE;
    mask_c = lim_m1;
    for (int i = 1; i < IDX_W; i++) mask_c = mask_c | (lim_m1 >> i);
  end

  assign cand = rnd[IDX_W-1:0] & mask_q;

  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    mask_d  = mask_q;
    try_d   = try_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    fb_d    = fb_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        lim_d  = limit;
        mask_d = mask_c;
        try_d  = '0;
        gap_d  = GAP_M1;
        if (limit == '0) begin
          state_d = DONE;
          idx_d   = '0;
          err_d   = 1'b1;
          fb_d    = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (gap_q == '0) state_d = SAMPLE;
        else             gap_d   = gap_q - 8'd1;
      end
      SAMPLE: begin
        if (cand < lim_q) begin
          idx_d   = cand;
          fb_d    = 1'b0;
          state_d = DONE;
        end else if (try_q + 8'd1 == MT) begin
          // cand <= mask < 2*lim, so the difference is always below lim.
          idx_d   = cand - lim_q;
          fb_d    = 1'b1;
          state_d = DONE;
        end else begin
          try_d   = try_q + 8'd1;
          gap_d   = GAP_M1;
          state_d = WAIT;
        end
      end
      DONE: if (idx_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
        fb_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      lim_q   <= '0;
      mask_q  <= '0;
      try_q   <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      fb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      mask_q  <= mask_d;
      try_q   <= try_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      fb_q    <= fb_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign idx_valid    = (state_q == DONE);
  assign idx          = idx_q;
  assign idx_fallback = fb_q;
  assign err          = err_q;

endmodule

// File: tb/tb_rand_index_sampler.sv
module tb_rand_index_sampler;
  localparam int WIDTH = 32, IDX_W = 8, GAP = 8, MAX_TRIES = 16;

  logic             clk = 0, reset = 0;
  logic [WIDTH-1:0] rnd = '0;
  logic             req_valid = 0, idx_ready = 0;
  logic [IDX_W-1:0] limit = '0;
  logic             req_ready, idx_valid, idx_fallback, err;
  logic [IDX_W-1:0] idx;

  typedef struct {
    logic [7:0] idx;
    logic       fb;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;

  rand_index_sampler #(.WIDTH(WIDTH), .IDX_W(IDX_W), .GAP(GAP), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .reset(reset), .rnd(rnd), .req_valid(req_valid), .req_ready(req_ready),
    .limit(limit), .idx_valid(idx_valid), .idx_ready(idx_ready), .idx(idx),
    .idx_fallback(idx_fallback), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one request and score the result. rnd[7:0]=r0 is seen at edges
  // 1..sw after acceptance and r1 afterwards. With bp set, the result is
  // held under backpressure for 5 cycles before it is taken.
  task automatic run_req(input string nm, input logic [7:0] lim, input logic [7:0] r0,
                         input logic [7:0] r1, input int sw, input exp_t e, input bit bp);
    int n;
    exp_t x;
    logic [7:0] held;
    @(negedge clk);
    limit = lim; rnd = {24'hA5C3F1, r0}; req_valid = 1;
    @(posedge clk);            // acceptance edge E0
    sb.push_back(e);
    #1 req_valid = 0;
    n = 0;
    while (n < 400) begin
      @(posedge clk); n++;
      #1;
      if (n == sw) rnd = {24'h3C5A96, r1};
      if (idx_valid) break;
    end
    n_chk++;
    if (!idx_valid) begin
      n_fail++; $display("FAIL %s timeout: idx_valid=%0b after %0d edges, required 1", nm, idx_valid, n);
      sb.delete();
      return;
    end
    x = sb.pop_front();
    n_chk++; if (n !== x.lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", nm, n, x.lat); end
    n_chk++; if (idx !== x.idx) begin n_fail++; $display("FAIL %s idx: got %0d required %0d", nm, idx, x.idx); end
    n_chk++; if (idx_fallback !== x.fb) begin n_fail++; $display("FAIL %s fallback: got %0b required %0b", nm, idx_fallback, x.fb); end
    n_chk++; if (err !== x.err) begin n_fail++; $display("FAIL %s err: got %0b required %0b", nm, err, x.err); end
    if (bp) begin
      held = idx;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        req_valid = ~req_valid; rnd = $urandom; limit = 8'(k + 3);
        @(posedge clk); #1;
        n_chk++; if (idx_valid !== 1'b1 || idx !== held) begin
          n_fail++; $display("FAIL %s bp hold: idx_valid=%0b idx=%0d required 1/%0d", nm, idx_valid, idx, held);
        end
        n_chk++; if (req_ready !== 1'b0) begin
          n_fail++; $display("FAIL %s bp req_ready: got %0b required 0", nm, req_ready);
        end
      end
      req_valid = 0;
    end
    idx_ready = 1;
    @(posedge clk); #1;
    idx_ready = 0;
    n_chk++; if (idx_valid !== 1'b0 || req_ready !== 1'b1 || err !== 1'b0 || idx_fallback !== 1'b0) begin
      n_fail++; $display("FAIL %s release: valid=%0b ready=%0b err=%0b fb=%0b required 0/1/0/0",
                         nm, idx_valid, req_ready, err, idx_fallback);
    end
  endtask

  task automatic test_reset();
    #3;
    n_chk++; if (req_ready !== 1'b1 || idx_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset hs: ready=%0b valid=%0b required 1/0", req_ready, idx_valid);
    end
    n_chk++; if (idx !== 8'd0 || idx_fallback !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset out: idx=%0d fb=%0b err=%0b required 0/0/0", idx, idx_fallback, err);
    end
    @(negedge clk); reset = 1;
  endtask

  task automatic test_first_draw();
    run_req("first_draw", 8'd10, 8'h07, 8'h07, 0, '{8'd7, 1'b0, 1'b0, GAP + 1}, 0);
  endtask

  task automatic test_retry();
    run_req("retry", 8'd10, 8'h0C, 8'h03, GAP + 1, '{8'd3, 1'b0, 1'b0, 2 * (GAP + 1)}, 0);
  endtask

  task automatic test_fallback();
    run_req("fallback", 8'd10, 8'h0F, 8'h0F, 0, '{8'd5, 1'b1, 1'b0, MAX_TRIES * (GAP + 1)}, 0);
  endtask

  task automatic test_limits();
    run_req("limit0", 8'd0, 8'h55, 8'h55, 0, '{8'd0, 1'b0, 1'b1, 1}, 0);
    run_req("limit1", 8'd1, 8'hFF, 8'hFF, 0, '{8'd0, 1'b0, 1'b0, GAP + 1}, 0);
    // limit=255: mask 0xFF, rnd 0xFE is the largest in-range value
    run_req("limit255", 8'd255, 8'hFE, 8'hFE, 0, '{8'd254, 1'b0, 1'b0, GAP + 1}, 0);
  endtask

  task automatic test_backpressure();
    run_req("backpressure", 8'd10, 8'h04, 8'h04, 0, '{8'd4, 1'b0, 1'b0, GAP + 1}, 1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    limit = 8'd10; rnd = 32'h0000_0009; req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;             // between edges, DUT is mid-WAIT
    #1;
    n_chk++; if (idx_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL async_reset: valid=%0b ready=%0b required 0/1", idx_valid, req_ready);
    end
    @(negedge clk); reset = 1;
    run_req("after_reset", 8'd10, 8'h02, 8'h02, 0, '{8'd2, 1'b0, 1'b0, GAP + 1}, 0);
  endtask

  task automatic test_back_to_back();
    run_req("b2b_a", 8'd6, 8'h05, 8'h05, 0, '{8'd5, 1'b0, 1'b0, GAP + 1}, 0);
    // limit=6 -> mask 7; 0x0E&7=6 rejected, then 0x01 accepted
    run_req("b2b_b", 8'd6, 8'h0E, 8'h01, GAP + 1, '{8'd1, 1'b0, 1'b0, 2 * (GAP + 1)}, 0);
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_retry();
    test_fallback();
    test_limits();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
